// File: rtl/ex_stage.sv
// Execute stage: ID->EX pipeline register, ALU, HI/LO and data SRAM request.
// Define EX_DIV_EN to build the iterative divider; without it div/divu are no-ops on HI/LO.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  output logic         stallreq_for_ex,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  logic [158:0] id_q;
  logic [31:0]  hi_q, lo_q;

  always_ff @(posedge clk) begin
    if (!rst)                       id_q <= '0;
    else if (stall[2] && !stall[3]) id_q <= '0;
    else if (!stall[2])             id_q <= id_to_ex_bus;
  end

  logic [31:0] pc, inst, rs_val, rt_val;
  logic [11:0] alu_op;
  logic [2:0]  src1_sel;
  logic [3:0]  src2_sel, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  assign {pc, inst, alu_op, src1_sel, src2_sel, ram_en, ram_wen,
          rf_we, rf_waddr, sel_rf_res, rs_val, rt_val} = id_q;

  logic special, is_mfhi, is_mflo, is_mthi, is_mtlo;
  assign special = (inst[31:26] == 6'h00);
  assign is_mfhi = special && (inst[5:0] == 6'h10);
  assign is_mthi = special && (inst[5:0] == 6'h11);
  assign is_mflo = special && (inst[5:0] == 6'h12);
  assign is_mtlo = special && (inst[5:0] == 6'h13);

  logic unused_ok;
  assign unused_ok = ^{stall[5:4], stall[1:0], inst[25:16]};

  logic [31:0] src1, src2, alu_res, imm_s, imm_z;
  assign imm_s = {{16{inst[15]}}, inst[15:0]};
  assign imm_z = {16'b0, inst[15:0]};

  always_comb begin
    src1 = ({32{src1_sel[0]}} & rs_val)
         | ({32{src1_sel[1]}} & pc)
         | ({32{src1_sel[2]}} & {27'b0, inst[10:6]});
    src2 = ({32{src2_sel[0]}} & rt_val)
         | ({32{src2_sel[1]}} & imm_s)
         | ({32{src2_sel[2]}} & 32'd8)
         | ({32{src2_sel[3]}} & imm_z);
    alu_res = '0;
    if (alu_op[11]) alu_res = alu_res | (src1 + src2);
    if (alu_op[10]) alu_res = alu_res | (src1 - src2);
    if (alu_op[9])  alu_res = alu_res | {31'b0, $signed(src1) < $signed(src2)};
    if (alu_op[8])  alu_res = alu_res | {31'b0, src1 < src2};
    if (alu_op[7])  alu_res = alu_res | (src1 & src2);
    if (alu_op[6])  alu_res = alu_res | ~(src1 | src2);
    if (alu_op[5])  alu_res = alu_res | (src1 | src2);
    if (alu_op[4])  alu_res = alu_res | (src1 ^ src2);
    if (alu_op[3])  alu_res = alu_res | (src2 << src1[4:0]);
    if (alu_op[2])  alu_res = alu_res | (src2 >> src1[4:0]);
    if (alu_op[1])  alu_res = alu_res | 32'($signed(src2) >>> src1[4:0]);
    if (alu_op[0])  alu_res = alu_res | {src2[15:0], 16'b0};
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
  div_state_e  state_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [4:0]  cnt_q;
  logic        quo_neg_q, rem_neg_q, dz_q;
  logic        is_div, is_sdiv;
  logic [32:0] rem_sh, diff;
  logic [31:0] quo_nx, rem_nx, quo_fix, rem_fix;

  assign is_sdiv = special && (inst[5:0] == 6'h1A);
  assign is_div  = is_sdiv || (special && (inst[5:0] == 6'h1B));

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[32]) begin
      rem_nx = diff[31:0];
      quo_nx = {quo_q[30:0], 1'b1};
    end else begin
      rem_nx = rem_sh[31:0];
      quo_nx = {quo_q[30:0], 1'b0};
    end
    quo_fix = quo_neg_q ? -quo_nx : quo_nx;
    rem_fix = rem_neg_q ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      if (is_mthi && !stall[3]) hi_q <= rs_val;
      if (is_mtlo && !stall[3]) lo_q <= rs_val;
      unique case (state_q)
        DIV_IDLE: if (is_div) begin
          state_q   <= DIV_BUSY;
          quo_q     <= (is_sdiv && rs_val[31]) ? -rs_val : rs_val;
          dvs_q     <= (is_sdiv && rt_val[31]) ? -rt_val : rt_val;
          rem_q     <= '0;
          cnt_q     <= '0;
          quo_neg_q <= is_sdiv && (rs_val[31] ^ rt_val[31]);
          rem_neg_q <= is_sdiv && rs_val[31];
          dz_q      <= (rt_val == 32'd0);
        end
        DIV_BUSY: begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DIV_DONE;
            hi_q    <= dz_q ? rs_val : rem_fix;
            lo_q    <= dz_q ? '1     : quo_fix;
          end
        end
        DIV_DONE: if (!stall[2]) state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  assign stallreq_for_ex = ((state_q == DIV_IDLE) && is_div) || (state_q == DIV_BUSY);
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (is_mthi && !stall[3]) hi_q <= rs_val;
      if (is_mtlo && !stall[3]) lo_q <= rs_val;
    end
  end

  assign stallreq_for_ex = 1'b0;
`endif

  logic [31:0] ex_result;
  logic        rf_we_o, ram_en_o;
  logic [3:0]  ram_wen_o;
  logic [4:0]  rf_waddr_o;

  assign ex_result  = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);
  assign rf_we_o    = (rf_we || is_mfhi || is_mflo) && !stallreq_for_ex;
  assign rf_waddr_o = (is_mfhi || is_mflo) ? inst[15:11] : rf_waddr;
  assign ram_en_o   = ram_en && !stallreq_for_ex;
  assign ram_wen_o  = stallreq_for_ex ? 4'b0 : ram_wen;

  assign ex_to_mem_bus   = {pc, ram_en_o, ram_wen_o, sel_rf_res, rf_we_o, rf_waddr_o, ex_result};
  assign data_sram_en    = ram_en_o;
  assign data_sram_wen   = ram_wen_o;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = rt_val;

endmodule
